// File: rtl/tdp36k_readback_pkg.sv
// ---------------------------------------------------------------------------
// tdp36k_pkg
// Shared definitions for the TDP36K readback engine:
//   - mode codes for the supported port width configurations
//   - sweep state encoding
//   - unpack(): maps a raw 18-bit RAM word to the configured data width
// ---------------------------------------------------------------------------
package tdp36k_pkg;

  // Port width configuration codes (8/16-bit widths share the 9/18 modes).
  localparam logic [2:0] MODE_1  = 3'd0;
  localparam logic [2:0] MODE_2  = 3'd1;
  localparam logic [2:0] MODE_4  = 3'd2;
  localparam logic [2:0] MODE_9  = 3'd3;
  localparam logic [2:0] MODE_18 = 3'd4;
  localparam logic [2:0] MODE_36 = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rb_state_e;

  // In 9-bit mode the parity bit lives at bit 16 of the 18-bit word, so it
  // is pulled down next to the byte. Every other width is LSB-aligned; the
  // caller keeps the low DBITS bits of the result.
  function automatic logic [17:0] unpack(input int dbits, input logic [17:0] word);
    logic [17:0] res;
    if (dbits == 32'sd9) begin
      res = {9'd0, word[16], word[7:0]};
    end else begin
      res = word;
    end
    return res;
  endfunction

endpackage

// File: rtl/tdp36k_rb_fifo.sv
// ---------------------------------------------------------------------------
// tdp36k_rb_fifo
// Two-entry output buffer for the readback engine. Each entry carries the
// unpacked data word plus its LAST tag.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   flush         drops all entries (takes priority over push/pop)
//   push, wdata   write one entry
//   pop           consume the head entry (only when count != 0)
//   rdata         head entry, held stable until popped
//   count         number of buffered entries (0..2)
// ---------------------------------------------------------------------------
module tdp36k_rb_fifo #(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic [1:0]   count
);

  logic [W-1:0] mem_r [2];
  logic         wr_ptr_r;
  logic         rd_ptr_r;
  logic [1:0]   count_r;

  // Storage, pointers and occupancy; flush empties the buffer in one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else if (flush) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_r + {1'b0, push} - {1'b0, pop};
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/tdp36k_readback.sv
// ---------------------------------------------------------------------------
// tdp36k_readback
// Sweeps ADDR_FIRST..ADDR_LAST on one read port of an 18K TDP36K half,
// unpacks each word to DBITS and streams it out on VALID/READY.
// Ports:
//   CLK_i, RSTN_i              clock, synchronous active-low reset
//   START_i, ABORT_i           begin / terminate a sweep
//   ADDR_FIRST_i, ADDR_LAST_i  inclusive range, sampled on START_i
//   REN_o, ADDR_o, RDATA_i     RAM read port (data one cycle after REN_o)
//   DATA_o, VALID_o, READY_i   unpacked output stream
//   LAST_o                     marks the word read from ADDR_LAST
//   BUSY_o, DONE_o, ERR_o      status: sweep active, last word taken,
//                              START with an inverted range
//   CHECKSUM_o                 XOR of accepted words; only present when
//                              TDP36K_READBACK_CHECKSUM_EN is defined
// ---------------------------------------------------------------------------
module tdp36k_readback
  import tdp36k_pkg::*;
#(
  parameter int DBITS = 18,
  parameter int ABITS = 14
) (
  input  logic             CLK_i,
  input  logic             RSTN_i,
  input  logic             START_i,
  input  logic             ABORT_i,
  input  logic [ABITS-1:0] ADDR_FIRST_i,
  input  logic [ABITS-1:0] ADDR_LAST_i,
  output logic             REN_o,
  output logic [ABITS-1:0] ADDR_o,
  input  logic [17:0]      RDATA_i,
  output logic [DBITS-1:0] DATA_o,
  output logic             VALID_o,
  input  logic             READY_i,
  output logic             LAST_o,
  output logic             BUSY_o,
  output logic             DONE_o,
  output logic             ERR_o
`ifdef TDP36K_READBACK_CHECKSUM_EN
  ,
  output logic [DBITS-1:0] CHECKSUM_o
`endif
);

  rb_state_e      state_r;
  logic [ABITS:0] addr_r;   // one spare bit so the top address compares cleanly
  logic [ABITS:0] last_r;
  logic           inflight_r;
  logic           inflight_last_r;
  logic           err_r;

  logic [1:0]     fifo_count_s;
  logic [DBITS:0] fifo_rdata_s;
  logic [17:0]    unpacked_s;
  logic           pop_s;
  logic           issue_s;
  logic           at_last_s;
  logic           drained_s;
  logic           start_ok_s;

  assign VALID_o   = (fifo_count_s != 2'd0);
  assign pop_s     = VALID_o & READY_i;
  // Issue only if the word can still land in the buffer even if nothing
  // more is consumed after this cycle.
  assign issue_s   = (state_r == RUN) &&
                     (({1'b0, fifo_count_s} + {2'b00, inflight_r} - {2'b00, pop_s}) < 3'd2);
  assign at_last_s = (addr_r == last_r);
  assign drained_s = !inflight_r &&
                     ((fifo_count_s == 2'd0) || ((fifo_count_s == 2'd1) && pop_s));
  assign start_ok_s = (state_r == IDLE) && START_i && !ABORT_i &&
                      (ADDR_LAST_i >= ADDR_FIRST_i);
  assign unpacked_s = unpack(DBITS, RDATA_i);

  // Sweep control: range latch, address stepping, in-flight tracking.
  always_ff @(posedge CLK_i) begin
    if (!RSTN_i) begin
      state_r         <= IDLE;
      addr_r          <= '0;
      last_r          <= '0;
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
      err_r           <= 1'b0;
    end else begin
      err_r           <= 1'b0;
      inflight_r      <= issue_s;
      inflight_last_r <= issue_s & at_last_s;
      if (ABORT_i) begin
        state_r         <= IDLE;
        inflight_r      <= 1'b0;
        inflight_last_r <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (START_i) begin
              if (ADDR_LAST_i < ADDR_FIRST_i) begin
                err_r <= 1'b1;
              end else begin
                addr_r  <= {1'b0, ADDR_FIRST_i};
                last_r  <= {1'b0, ADDR_LAST_i};
                state_r <= RUN;
              end
            end
          end
          RUN: begin
            if (issue_s) begin
              if (at_last_s) begin
                // Address holds at ADDR_LAST so the port never wraps.
                state_r <= DRAIN;
              end else begin
                addr_r <= addr_r + {{ABITS{1'b0}}, 1'b1};
              end
            end
          end
          DRAIN: begin
            if (drained_s) begin
              state_r <= IDLE;
            end
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  tdp36k_rb_fifo #(
    .W (DBITS + 1)
  ) u_fifo (
    .clk   (CLK_i),
    .rst_n (RSTN_i),
    .flush (ABORT_i),
    .push  (inflight_r),
    .wdata ({inflight_last_r, unpacked_s[DBITS-1:0]}),
    .pop   (pop_s),
    .rdata (fifo_rdata_s),
    .count (fifo_count_s)
  );

  assign REN_o  = issue_s;
  assign ADDR_o = addr_r[ABITS-1:0];
  assign DATA_o = fifo_rdata_s[DBITS-1:0];
  assign LAST_o = VALID_o & fifo_rdata_s[DBITS];
  assign BUSY_o = (state_r != IDLE);
  assign DONE_o = pop_s & LAST_o & !ABORT_i;
  assign ERR_o  = err_r;

`ifdef TDP36K_READBACK_CHECKSUM_EN
  logic [DBITS-1:0] checksum_r;

  // Running XOR of accepted words, cleared when a sweep is accepted.
  always_ff @(posedge CLK_i) begin
    if (!RSTN_i) begin
      checksum_r <= '0;
    end else if (start_ok_s) begin
      checksum_r <= '0;
    end else if (pop_s) begin
      checksum_r <= checksum_r ^ DATA_o;
    end
  end

  assign CHECKSUM_o = checksum_r;
`endif

endmodule

// File: tb/tb_tdp36k_readback.sv
// ---------------------------------------------------------------------------
// tb_tdp36k_readback
// Self-checking bench for tdp36k_readback. Two instances (DBITS=18 and
// DBITS=9) share one RAM model and one set of inputs. A negedge monitor
// keeps a queue-based reference of issued addresses and expected beats.
// ---------------------------------------------------------------------------
module tb_tdp36k_readback;

  localparam int ABITS = 14;

  logic             clk;
  logic             rstn;
  logic             start;
  logic             abort;
  logic [ABITS-1:0] addr_first;
  logic [ABITS-1:0] addr_last;
  logic             ready;
  logic [17:0]      rdata;

  logic             ren;
  logic [ABITS-1:0] addr;
  logic [17:0]      data;
  logic             valid;
  logic             last;
  logic             busy;
  logic             done;
  logic             err;

  logic             ren9;
  logic [ABITS-1:0] addr9;
  logic [8:0]       data9;
  logic             valid9;
  logic             last9;
  logic             busy9;
  logic             done9;
  logic             err9;
`ifdef TDP36K_READBACK_CHECKSUM_EN
  logic [17:0]      checksum;
  logic [8:0]       checksum9;
`endif

  tdp36k_readback #(.DBITS(18), .ABITS(ABITS)) dut (
    .CLK_i(clk), .RSTN_i(rstn), .START_i(start), .ABORT_i(abort),
    .ADDR_FIRST_i(addr_first), .ADDR_LAST_i(addr_last),
    .REN_o(ren), .ADDR_o(addr), .RDATA_i(rdata),
    .DATA_o(data), .VALID_o(valid), .READY_i(ready), .LAST_o(last),
    .BUSY_o(busy), .DONE_o(done), .ERR_o(err)
`ifdef TDP36K_READBACK_CHECKSUM_EN
    , .CHECKSUM_o(checksum)
`endif
  );

  tdp36k_readback #(.DBITS(9), .ABITS(ABITS)) dut9 (
    .CLK_i(clk), .RSTN_i(rstn), .START_i(start), .ABORT_i(abort),
    .ADDR_FIRST_i(addr_first), .ADDR_LAST_i(addr_last),
    .REN_o(ren9), .ADDR_o(addr9), .RDATA_i(rdata),
    .DATA_o(data9), .VALID_o(valid9), .READY_i(ready), .LAST_o(last9),
    .BUSY_o(busy9), .DONE_o(done9), .ERR_o(err9)
`ifdef TDP36K_READBACK_CHECKSUM_EN
    , .CHECKSUM_o(checksum9)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registered read, data valid the cycle after REN.
  logic [17:0] mem [0:16383];
  always @(posedge clk) begin
    if (ren) rdata <= mem[addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] to9(input logic [17:0] w);
    return {w[16], w[7:0]};
  endfunction

  // ---------------- reference model ----------------
  typedef struct { logic [17:0] word; logic is_last; } beat_t;
  beat_t       exp_q[$];
  int          addr_q[$];
  logic [8:0]  got9_q[$];
  int          issued, accepted, n_done;
  logic        err_pend;
  logic [17:0] ck18;
  logic [8:0]  ck9;

  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete(); addr_q.delete(); got9_q.delete();
      issued = 0; accepted = 0; err_pend = 1'b0; ck18 = '0; ck9 = '0;
    end else begin
      logic hs;
      hs = valid & ready;
      check("lockstep_ren", {31'd0, ren9}, {31'd0, ren});
      if (ren) begin
        check("ren_when_busy", {31'd0, busy}, 32'd1);
        check("credit", (issued - accepted - (hs ? 1 : 0)) < 2 ? 32'd1 : 32'd0, 32'd1);
        if (addr_q.size() == 0) check("ren_extra", 32'd1, 32'd0);
        else check("ren_addr", {18'd0, addr}, addr_q.pop_front());
        issued++;
      end
      if (hs) begin
        if (exp_q.size() == 0) begin
          check("beat_extra", 32'd1, 32'd0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("data", {14'd0, data}, {14'd0, e.word});
          check("data9", {23'd0, data9}, {23'd0, to9(e.word)});
          check("last", {31'd0, last}, {31'd0, e.is_last});
          check("done", {31'd0, done}, {31'd0, e.is_last & ~abort});
          if (e.is_last && !abort) n_done++;
        end
        accepted++;
        got9_q.push_back(data9);
        ck18 = ck18 ^ data;
        ck9  = ck9 ^ data9;
      end else if (done) begin
        check("done_spurious", 32'd1, 32'd0);
      end
      if (err || err_pend) check("err", {31'd0, err}, {31'd0, err_pend});
      err_pend = 1'b0;
      if (abort) begin
        exp_q.delete(); addr_q.delete();
        issued = 0; accepted = 0;
      end else if (start && !busy) begin
        if (addr_last < addr_first) begin
          err_pend = 1'b1;
        end else begin
          issued = 0; accepted = 0; ck18 = '0; ck9 = '0;
          got9_q.delete();
          for (int a = int'(addr_first); a <= int'(addr_last); a++) begin
            beat_t b;
            b.word = mem[a];
            b.is_last = (a == int'(addr_last));
            addr_q.push_back(a);
            exp_q.push_back(b);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses START for one cycle; returns in cycle t+1.
  task automatic kick(input int f, input int l);
    start = 1'b1;
    addr_first = f[ABITS-1:0];
    addr_last = l[ABITS-1:0];
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit rand_ready);
    int n;
    n = 0;
    while (busy && n < budget) begin
      if (rand_ready) ready = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    if (busy) check("timeout", 32'd1, 32'd0);
    ready = 1'b1;
  endtask

  task automatic check_sum();
`ifdef TDP36K_READBACK_CHECKSUM_EN
    check("checksum", {14'd0, checksum}, {14'd0, ck18});
    check("checksum9", {23'd0, checksum9}, {23'd0, ck9});
`endif
  endtask

  initial begin
    int done0;
    logic [17:0] held;
    rstn = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0;
    addr_first = '0; addr_last = '0;
    for (int a = 0; a < 16384; a++) mem[a] = 18'($urandom);

    // Reset state
    repeat (3) tick();
    check("rst_ren", {31'd0, ren}, 32'd0);
    check("rst_addr", {18'd0, addr}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_data", {14'd0, data}, 32'd0);
    check("rst_last", {31'd0, last}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
`ifdef TDP36K_READBACK_CHECKSUM_EN
    check("rst_checksum", {14'd0, checksum}, 32'd0);
`endif
    rstn = 1'b1;
    tick();

    // Sweep 0..3, RDATA = addr + 0x100, full-rate timing.
    for (int a = 0; a < 4; a++) mem[a] = 18'(32'h100 + a);
    ready = 1'b1;
    kick(0, 3);
    for (int k = 1; k <= 7; k++) begin
      check("t1_ren", {31'd0, ren}, (k <= 4) ? 32'd1 : 32'd0);
      check("t1_valid", {31'd0, valid}, (k >= 3 && k <= 6) ? 32'd1 : 32'd0);
      if (k >= 3 && k <= 6) check("t1_data", {14'd0, data}, 32'h100 + k - 3);
      check("t1_last", {31'd0, last}, (k == 6) ? 32'd1 : 32'd0);
      check("t1_done", {31'd0, done}, (k == 6) ? 32'd1 : 32'd0);
      check("t1_busy", {31'd0, busy}, (k <= 6) ? 32'd1 : 32'd0);
      tick();
    end
`ifdef TDP36K_READBACK_CHECKSUM_EN
    check("t1_checksum", {14'd0, checksum}, 32'h000);
`endif

    // 9-bit unpacking
    mem[10] = 18'h100A5;
    mem[11] = 18'h0FF5A;
    kick(10, 11);
    wait_idle(50, 1'b0);
    check("t2_count", got9_q.size(), 32'd2);
    if (got9_q.size() >= 2) begin
      check("t2_w0", {23'd0, got9_q[0]}, 32'h1A5);
      check("t2_w1", {23'd0, got9_q[1]}, 32'h05A);
    end

    // Backpressure mid-sweep on 0..7
    kick(0, 7);
    repeat (3) tick();
    ready = 1'b0;
    held = data;
    for (int s = 0; s < 4; s++) begin
      check("t3_valid", {31'd0, valid}, 32'd1);
      check("t3_hold", {14'd0, data}, {14'd0, held});
      if (s >= 1) check("t3_ren_stall", {31'd0, ren}, 32'd0);
      tick();
    end
    ready = 1'b1;
    wait_idle(50, 1'b0);
    check("t3_count", accepted, 32'd8);

    // Top-of-range single beat
    done0 = n_done;
    kick(16383, 16383);
    wait_idle(50, 1'b0);
    check("t4_addr", {18'd0, addr}, 32'h3FFF);
    check("t4_dones", n_done - done0, 32'd1);
    check("t4_beats", accepted, 32'd1);

    // Inverted range
    kick(5, 2);
    check("t5_err", {31'd0, err}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      check("t5_busy", {31'd0, busy}, 32'd0);
      check("t5_ren", {31'd0, ren}, 32'd0);
      tick();
    end

    // Abort at word 3 of 0..15, then immediate restart
    done0 = n_done;
    kick(0, 15);
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_valid", {31'd0, valid}, 32'd0);
    check("t6_ren", {31'd0, ren}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_done", {31'd0, done}, 32'd0);
    kick(20, 22);
    check("t6_restart_busy", {31'd0, busy}, 32'd1);
    check("t6_restart_addr", {18'd0, addr}, 32'd20);
    wait_idle(50, 1'b0);
    check("t6_dones", n_done - done0, 32'd1);
    check_sum();

    // Randomized sweeps with random backpressure, stray starts and aborts
    for (int it = 0; it < 60; it++) begin
      int f, l, n;
      f = $urandom_range(0, 16383);
      l = f + $urandom_range(0, 11);
      if (l > 16383) l = 16383;
      if ($urandom_range(0, 9) == 0) begin
        n = f; f = l + 1; l = n;
        if (f > 16383) f = 16383;
      end
      kick(f, l);
      n = 0;
      while (busy && n < 300) begin
        ready = ($urandom_range(0, 3) != 0);
        start = ($urandom_range(0, 7) == 0);
        addr_first = 14'($urandom);
        addr_last = 14'($urandom);
        abort = ($urandom_range(0, 39) == 0);
        tick();
        start = 1'b0;
        abort = 1'b0;
        n++;
      end
      if (busy) check("rand_timeout", 32'd1, 32'd0);
      ready = 1'b1;
      tick();
      check("rand_drained", exp_q.size(), 32'd0);
      check_sum();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
